// File: rtl/id_stage_pkg.sv
// Shared widths, opcode/funct constants and instruction field layout for the ID stage.
package id_stage_pkg;

   localparam int unsigned NB_ADDR_DEF      = 32;
   localparam int unsigned NB_INST_DEF      = 32;
   localparam int unsigned NB_OPCODE_DEF    = 6;
   localparam int unsigned NB_FUNCT_DEF     = 6;
   localparam int unsigned NB_REG_DEF       = 5;
   localparam int unsigned NB_IMMEDIATE_DEF = 16;
   localparam int unsigned NB_DATA_DEF      = 32;
   localparam int unsigned SIZE_REG_DEF     = 32;

   localparam logic [5:0] OP_RTYPE       = 6'b000000;
   localparam logic [5:0] OP_BEQ         = 6'b000100;
   localparam logic [5:0] OP_BNE         = 6'b000101;
   localparam logic [2:0] OP_LOAD_PREFIX = 3'b100;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } inst_fields_t;

   // Shifts by immediate take the shamt field as ALU operand A.
   function automatic logic is_shift_imm(input logic [5:0] funct);
      return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
   endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: two operand read ports, one debug read port, one write port.
// Reads bypass the in-flight write so a value written this cycle is seen immediately.
module reg_file
   import id_stage_pkg::*;
#(
   parameter int unsigned NB_REG   = NB_REG_DEF,
   parameter int unsigned NB_DATA  = NB_DATA_DEF,
   parameter int unsigned SIZE_REG = SIZE_REG_DEF
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_REG-1:0]  i_waddr,
   input  logic [NB_DATA-1:0] i_wdata,
   input  logic [NB_REG-1:0]  i_raddr_a,
   input  logic [NB_REG-1:0]  i_raddr_b,
   input  logic [NB_REG-1:0]  i_raddr_dbg,
   output logic [NB_DATA-1:0] o_rdata_a,
   output logic [NB_DATA-1:0] o_rdata_b,
   output logic [NB_DATA-1:0] o_rdata_dbg
);

   logic [NB_DATA-1:0] mem [SIZE_REG];

   // One write every cycle; address 0 is hardwired to zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem <= '{default: '0};
      end else if (i_waddr != '0) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   function automatic logic [NB_DATA-1:0] read_port(input logic [NB_REG-1:0] addr);
      if (addr == '0)      return '0;
      if (addr == i_waddr) return i_wdata;
      return mem[addr];
   endfunction

   always_comb begin
      o_rdata_a   = read_port(i_raddr_a);
      o_rdata_b   = read_port(i_raddr_b);
      o_rdata_dbg = read_port(i_raddr_dbg);
   end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode, operand fetch and ID/EX pipeline register.
// Define ID_STAGE_DEBUG_PORT_EN to enable the debug register-file write/read port.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int unsigned NB_ADDR      = NB_ADDR_DEF,
   parameter int unsigned NB_INST      = NB_INST_DEF,
   parameter int unsigned NB_OPCODE    = NB_OPCODE_DEF,
   parameter int unsigned NB_FUNCT     = NB_FUNCT_DEF,
   parameter int unsigned NB_REG       = NB_REG_DEF,
   parameter int unsigned NB_IMMEDIATE = NB_IMMEDIATE_DEF,
   parameter int unsigned NB_DATA      = NB_DATA_DEF,
   parameter int unsigned SIZE_REG     = SIZE_REG_DEF
)(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NB_ADDR-1:0]  i_pc,
   input  logic [NB_INST-1:0]  i_instruction,
   input  logic [NB_DATA-1:0]  i_data_input,
   input  logic [NB_REG-1:0]   i_address_data,
   input  logic                i_write_debug_reg_file,
   input  logic [NB_REG-1:0]   i_address_write_debug,
   input  logic [NB_DATA-1:0]  i_write_data_debug,
   input  logic [NB_REG-1:0]   i_address_read_debug,
   output logic [NB_ADDR-1:0]  o_pc,
   output logic [NB_INST-1:0]  o_instruction,
   output logic [NB_FUNCT-1:0] o_funct,
   output logic [NB_DATA-1:0]  o_data_1,
   output logic [NB_DATA-1:0]  o_data_2,
   output logic [NB_REG-1:0]   o_rd,
   output logic [NB_DATA-1:0]  o_sign_extend,
   output logic                o_signal_control_mult_A,
   output logic                o_signal_control_mult_B,
   output logic                o_signal_control_mult_wb,
   output logic [NB_DATA-1:0]  o_data_read_debug
);

   inst_fields_t             fields;
   logic [NB_IMMEDIATE-1:0]  imm;
   logic [NB_REG-1:0]        waddr;
   logic [NB_DATA-1:0]       wdata;
   logic [NB_REG-1:0]        raddr_dbg;
   logic [NB_DATA-1:0]       rdata_a;
   logic [NB_DATA-1:0]       rdata_b;
   logic [NB_DATA-1:0]       rdata_dbg;

   logic                     is_rtype;
   logic [NB_REG-1:0]        rd_next;
   logic [NB_DATA-1:0]       sext_next;
   logic                     mult_a_next;
   logic                     mult_b_next;
   logic                     mult_wb_next;

   assign fields = inst_fields_t'(i_instruction);
   assign imm    = i_instruction[NB_IMMEDIATE-1:0];

`ifdef ID_STAGE_DEBUG_PORT_EN
   // Debug mode takes over the single write port for the whole cycle.
   assign waddr             = i_write_debug_reg_file ? i_address_write_debug : i_address_data;
   assign wdata             = i_write_debug_reg_file ? i_write_data_debug    : i_data_input;
   assign raddr_dbg         = i_address_read_debug;
   assign o_data_read_debug = rdata_dbg;
`else
   logic unused_debug;
   assign waddr             = i_address_data;
   assign wdata             = i_data_input;
   assign raddr_dbg         = '0;
   assign o_data_read_debug = '0;
   assign unused_debug      = ^{i_write_debug_reg_file, i_address_write_debug,
                                i_write_data_debug, i_address_read_debug, rdata_dbg};
`endif

   logic unused_fields;
   assign unused_fields = ^fields.shamt;

   reg_file #(
      .NB_REG   (NB_REG),
      .NB_DATA  (NB_DATA),
      .SIZE_REG (SIZE_REG)
   ) u_reg_file (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_waddr     (waddr),
      .i_wdata     (wdata),
      .i_raddr_a   (fields.rs),
      .i_raddr_b   (fields.rt),
      .i_raddr_dbg (raddr_dbg),
      .o_rdata_a   (rdata_a),
      .o_rdata_b   (rdata_b),
      .o_rdata_dbg (rdata_dbg)
   );

   // Control decode feeding the ID/EX register.
   always_comb begin
      is_rtype     = (fields.opcode == OP_RTYPE);
      rd_next      = is_rtype ? fields.rd : fields.rt;
      sext_next    = {{(NB_DATA-NB_IMMEDIATE){imm[NB_IMMEDIATE-1]}}, imm};
      mult_a_next  = is_rtype && is_shift_imm(fields.funct);
      mult_b_next  = !is_rtype && (fields.opcode != OP_BEQ) && (fields.opcode != OP_BNE);
      mult_wb_next = (fields.opcode[5:3] == OP_LOAD_PREFIX);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pc                     <= '0;
         o_instruction            <= '0;
         o_funct                  <= '0;
         o_data_1                 <= '0;
         o_data_2                 <= '0;
         o_rd                     <= '0;
         o_sign_extend            <= '0;
         o_signal_control_mult_A  <= 1'b0;
         o_signal_control_mult_B  <= 1'b0;
         o_signal_control_mult_wb <= 1'b0;
      end else begin
         o_pc                     <= i_pc;
         o_instruction            <= i_instruction;
         o_funct                  <= fields.funct;
         o_data_1                 <= rdata_a;
         o_data_2                 <= rdata_b;
         o_rd                     <= rd_next;
         o_sign_extend            <= sext_next;
         o_signal_control_mult_A  <= mult_a_next;
         o_signal_control_mult_B  <= mult_b_next;
         o_signal_control_mult_wb <= mult_wb_next;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expectations, a monitor pops and compares.
module tb_id_stage;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_pc = '0;
   logic [31:0] i_instruction = '0;
   logic [31:0] i_data_input = '0;
   logic [4:0]  i_address_data = '0;
   logic        i_write_debug_reg_file = 1'b0;
   logic [4:0]  i_address_write_debug = '0;
   logic [31:0] i_write_data_debug = '0;
   logic [4:0]  i_address_read_debug = '0;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
   logic [5:0]  o_funct;
   logic [31:0] o_data_1;
   logic [31:0] o_data_2;
   logic [4:0]  o_rd;
   logic [31:0] o_sign_extend;
   logic        o_signal_control_mult_A;
   logic        o_signal_control_mult_B;
   logic        o_signal_control_mult_wb;
   logic [31:0] o_data_read_debug;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [5:0]  funct;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic [31:0] sext;
      logic        ma;
      logic        mb;
      logic        mwb;
      logic [31:0] dbg;
   } exp_t;

   exp_t sb[$];

   id_stage dut (
      .i_clk                    (i_clk),
      .i_rst_n                  (i_rst_n),
      .i_pc                     (i_pc),
      .i_instruction            (i_instruction),
      .i_data_input             (i_data_input),
      .i_address_data           (i_address_data),
      .i_write_debug_reg_file   (i_write_debug_reg_file),
      .i_address_write_debug    (i_address_write_debug),
      .i_write_data_debug       (i_write_data_debug),
      .i_address_read_debug     (i_address_read_debug),
      .o_pc                     (o_pc),
      .o_instruction            (o_instruction),
      .o_funct                  (o_funct),
      .o_data_1                 (o_data_1),
      .o_data_2                 (o_data_2),
      .o_rd                     (o_rd),
      .o_sign_extend            (o_sign_extend),
      .o_signal_control_mult_A  (o_signal_control_mult_A),
      .o_signal_control_mult_B  (o_signal_control_mult_B),
      .o_signal_control_mult_wb (o_signal_control_mult_wb),
      .o_data_read_debug        (o_data_read_debug)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
      end
   endtask

   // The debug read port only carries data when the feature is built in.
   function automatic logic [31:0] dbg_exp(input logic [31:0] v);
`ifdef ID_STAGE_DEBUG_PORT_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   // Drive one cycle of stimulus at the falling edge and queue its expected ID/EX result.
   task automatic step(input int id, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] waddr, input logic [31:0] wdata, input logic [4:0] rdbg,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] sext, input logic ma, input logic mb, input logic mwb,
                       input logic [31:0] dbg_raw);
      exp_t e;
      @(negedge i_clk);
      i_pc                 = pc;
      i_instruction        = instr;
      i_address_read_debug = rdbg;
`ifdef ID_STAGE_DEBUG_PORT_EN
      i_write_debug_reg_file = 1'b1;
      i_address_write_debug  = waddr;
      i_write_data_debug     = wdata;
      i_address_data         = waddr;
      i_data_input           = ~wdata;
`else
      i_write_debug_reg_file = 1'b1;
      i_address_write_debug  = 5'd2;
      i_write_data_debug     = 32'hDEAD_BEEF;
      i_address_data         = waddr;
      i_data_input           = wdata;
`endif
      e.id = id; e.pc = pc; e.instr = instr; e.funct = instr[5:0];
      e.d1 = d1; e.d2 = d2; e.rd = rd; e.sext = sext;
      e.ma = ma; e.mb = mb; e.mwb = mwb; e.dbg = dbg_exp(dbg_raw);
      sb.push_back(e);
      @(posedge i_clk);
   endtask

   // Monitor: outputs are valid one cycle after each driven vector.
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("o_pc",    e.id, o_pc,          e.pc);
            chk("o_instr", e.id, o_instruction, e.instr);
            chk("o_funct", e.id, 32'(o_funct),  32'(e.funct));
            chk("o_data_1", e.id, o_data_1,     e.d1);
            chk("o_data_2", e.id, o_data_2,     e.d2);
            chk("o_rd",    e.id, 32'(o_rd),     32'(e.rd));
            chk("o_sext",  e.id, o_sign_extend, e.sext);
            chk("mult_A",  e.id, 32'(o_signal_control_mult_A),  32'(e.ma));
            chk("mult_B",  e.id, 32'(o_signal_control_mult_B),  32'(e.mb));
            chk("mult_wb", e.id, 32'(o_signal_control_mult_wb), 32'(e.mwb));
            chk("dbg_read", e.id, o_data_read_debug, e.dbg);
         end
      end
   end

   task automatic chk_all_zero(input int id);
      chk("rst o_pc",    id, o_pc, 32'h0);
      chk("rst o_instr", id, o_instruction, 32'h0);
      chk("rst o_funct", id, 32'(o_funct), 32'h0);
      chk("rst o_data_1", id, o_data_1, 32'h0);
      chk("rst o_data_2", id, o_data_2, 32'h0);
      chk("rst o_rd",    id, 32'(o_rd), 32'h0);
      chk("rst o_sext",  id, o_sign_extend, 32'h0);
      chk("rst mults",   id, 32'({o_signal_control_mult_A, o_signal_control_mult_B,
                                  o_signal_control_mult_wb}), 32'h0);
      chk("rst dbg_read", id, o_data_read_debug, 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      chk_all_zero(0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      //   id  pc     instr          wa  wdata     rdbg d1  d2  rd  sext          A  B  wb dbg
      step(1,  32'd0, 32'h0000_0000, 1,  32'd7,    0,   0,  0,  0,  32'h0,        1, 0, 0, 0);
      step(2,  32'd0, 32'h0000_0000, 2,  32'd8,    1,   0,  0,  0,  32'h0,        1, 0, 0, 7);
      step(3,  32'd0, 32'h0000_0000, 3,  32'd0,    2,   0,  0,  0,  32'h0,        1, 0, 0, 8);
      step(4,  32'd4, 32'h0022_1820, 0,  32'h99,   3,   7,  8,  3,  32'h0000_1820, 0, 0, 0, 0);
      step(5,  32'd1, 32'h8C23_0004, 0,  32'h0,    1,   7,  0,  3,  32'h0000_0004, 0, 1, 1, 7);
      step(6,  32'd8, 32'h2022_FFFF, 0,  32'h0,    1,   7,  8,  2,  32'hFFFF_FFFF, 0, 1, 0, 7);
      step(7,  32'd12, 32'h0002_1080, 0, 32'h0,    2,   0,  8,  2,  32'h0000_1080, 1, 0, 0, 8);
      step(8,  32'd16, 32'h1022_0003, 0, 32'h0,    0,   7,  8,  2,  32'h0000_0003, 0, 0, 0, 0);
      step(9,  32'd20, 32'h0000_0000, 0, 32'h55,   0,   0,  0,  0,  32'h0,        1, 0, 0, 0);
      step(10, 32'd24, 32'h0022_1820, 1, 32'd9,    1,   9,  8,  3,  32'h0000_1820, 0, 0, 0, 9);
      step(11, 32'd28, 32'h1422_0003, 0, 32'h0,    1,   9,  8,  2,  32'h0000_0003, 0, 0, 0, 9);
      step(12, 32'd32, 32'h0002_1083, 0, 32'h0,    2,   0,  8,  2,  32'h0000_1083, 1, 0, 0, 8);

      // Mid-cycle asynchronous reset with the register file populated.
      @(negedge i_clk);
      i_write_debug_reg_file = 1'b0;
      i_address_data         = 5'd0;
      i_address_write_debug  = 5'd0;
      i_address_read_debug   = 5'd1;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_all_zero(13);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      step(14, 32'd40, 32'h0022_1820, 0, 32'h0,    1,   0,  0,  3,  32'h0000_1820, 0, 0, 0, 0);

      @(posedge i_clk);
      #2;
      chk("scoreboard drained", 99, 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 NB_ADDR 32 PC width; NB_INST 32 instruction width; NB_OPCODE 6 opcode field; NB_FUNCT 6 funct field;
 NB_REG 5 register-address width; NB_IMMEDIATE 16 immediate field; NB_DATA 32 data width; SIZE_REG 32 register count.
REQ-002 Ports (name direction width meaning), clock and reset first:
 i_clk in 1 single clock, rising edge; i_rst_n in 1 reset, asynchronous, active-low;
 i_pc in NB_ADDR incoming PC; i_instruction in NB_INST instruction to decode;
 i_data_input in NB_DATA writeback data; i_address_data in NB_REG writeback register address;
 i_write_debug_reg_file in 1 debug-write mode select; i_address_write_debug in NB_REG debug write address;
 i_write_data_debug in NB_DATA debug write data; i_address_read_debug in NB_REG debug read address;
 o_pc out NB_ADDR; o_instruction out NB_INST; o_funct out NB_FUNCT; o_data_1 out NB_DATA rs value;
 o_data_2 out NB_DATA rt value; o_rd out NB_REG destination register; o_sign_extend out NB_DATA extended immediate;
 o_signal_control_mult_A out 1 ALU-A mux select; o_signal_control_mult_B out 1 ALU-B mux select;
 o_signal_control_mult_wb out 1 writeback mux select; o_data_read_debug out NB_DATA debug read data.

Function
REQ-003 Register file: SIZE_REG x NB_DATA; register 0 reads 0 always; writes to address 0 are dropped.
REQ-004 Write on rising i_clk: i_write_debug_reg_file=1 -> write i_write_data_debug to i_address_write_debug; else write i_data_input to i_address_data; exactly one write per cycle.
REQ-005 Reads are write-first: a register written in cycle N supplies its new value to the ID/EX outputs captured at that same edge.
REQ-006 Fields: rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], opcode=[31:26], immediate=[15:0].
REQ-007 All outputs except o_data_read_debug are registered (ID/EX register) and update every rising edge; latency one cycle from i_instruction/i_pc.
REQ-008 o_pc=i_pc; o_instruction=i_instruction; o_funct=funct; o_data_1=reg[rs]; o_data_2=reg[rt].
REQ-009 o_rd=rd when opcode==0 (R-type), else rt.
REQ-010 o_sign_extend = immediate sign-extended from bit 15 to NB_DATA.
REQ-011 mult_A=1 only for opcode 0 with funct 000000/000010/000011 (SLL/SRL/SRA, shamt operand), else 0.
REQ-012 mult_B=1 for opcode!=0 except BEQ(000100)/BNE(000101), else 0.
REQ-013 mult_wb=1 for load opcodes (100xxx), else 0.
REQ-014 o_data_read_debug = reg[i_address_read_debug], combinational, write-first as REQ-005.

Reset
REQ-015 i_rst_n low asynchronously clears all registered outputs and all registers of the register file to 0.
REQ-016 Writes are blocked while i_rst_n is low; first capture is the first rising edge after release.

Configuration
REQ-017 Macro ID_STAGE_DEBUG_PORT_EN: defined -> debug read/write behaves per REQ-004/REQ-014; undefined -> i_write_debug_reg_file and debug addresses/data ignored, writeback port always used, o_data_read_debug tied to 0.

Structure
REQ-018 Shared package holds the width constants of REQ-001 plus opcode/funct constants (R-type, BEQ, BNE, load prefix, SLL/SRL/SRA).
REQ-019 One sub-module, reg_file (two read ports, one debug read port, one write port, write-first), instantiated once; decode and ID/EX register stay in id_stage.

Verification
REQ-020 Debug writes r1=7, r2=8, r3=0, then ADD 0x00221820 -> next edge: o_data_1=7, o_data_2=8, o_rd=3, o_funct=0x20, o_sign_extend=0x00001820, mult A/B/wb=0/0/0.
REQ-021 i_address_read_debug=3 after REQ-020 writes -> o_data_read_debug=0; address 1 -> 7.
REQ-022 LW 0x8C230004 with i_pc=1 -> o_rd=3, o_sign_extend=4, mult_B=1, mult_wb=1, o_pc=1.
REQ-023 ADDI 0x2022FFFF -> o_sign_extend=0xFFFFFFFF, o_rd=2, mult_B=1; SLL 0x00021080 -> mult_A=1, o_rd=2.
REQ-024 Debug write 0x55 to r0 -> o_data_read_debug(0)=0; same-cycle write r1=9 with rs=1 -> o_data_1=9 at that edge.
REQ-025 Assert i_rst_n=0 mid-stream -> all outputs 0 immediately, r1 reads 0 after release.
